// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: protocol bytes, filter lists, the
// sequence-state enum and key indices used by the keyboard-mode FSMs.
package ps2_pkg;

    // Protocol prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes that are keyboard responses/errors rather than scan codes
    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_ECHO      = 8'hEE;
    localparam logic [7:0] PS2_OVERRUN0  = 8'h00;
    localparam logic [7:0] PS2_OVERRUNFF = 8'hFF;

    // Shift codes the keyboard injects around extended keys (after E0)
    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    // The pause sequence is E1 followed by seven more bytes
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Key indices {ext, code} consumed downstream
    localparam logic [8:0] KEY_CAPS   = 9'h058;
    localparam logic [8:0] KEY_LSHIFT = 9'h012;
    localparam logic [8:0] KEY_RSHIFT = 9'h059;
    localparam logic [8:0] KEY_LCTRL  = 9'h014;
    localparam logic [8:0] KEY_RCTRL  = 9'h114;
    localparam logic [8:0] KEY_LALT   = 9'h011;
    localparam logic [8:0] KEY_RALT   = 9'h111;

    // Where we are inside a multi-byte scan-code sequence
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } seq_state_e;

    // True for bytes that are never key codes when seen outside a sequence
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ACK)      || (b == PS2_BAT_OK) ||
               (b == PS2_RESEND)   || (b == PS2_ECHO)   ||
               (b == PS2_OVERRUN0) || (b == PS2_OVERRUNFF);
    endfunction

    // True for the fake-shift codes that may follow an E0 prefix
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Loadable down-counter that abandons a half-received scan-code sequence
// once the keyboard has been silent for TIMEOUT_CYCLES clocks.
module ps2_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic fcrystal,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    // Guard against a zero-width counter for degenerate parameter values
    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload on every byte; otherwise count down while enabled, saturating at 0
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge fcrystal or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the decrement that reaches zero, so the owner returns to idle
    // exactly TIMEOUT_CYCLES idle cycles after the load took effect.
    assign expired = en && !load && (count_q <= W'(1));

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the PS/2 byte stream into a 512-bit key-down bitmap indexed by
// {extended, code}, with a one-cycle key_valid pulse on every real toggle.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic         fcrystal,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid
);

    seq_state_e   state_q;
    seq_state_e   state_d;
    logic [2:0]   pause_cnt_q;
    logic [2:0]   pause_cnt_d;

    logic [511:0] key_down_q;
    logic [511:0] key_down_d;
    logic [8:0]   last_change_q;
    logic [8:0]   last_change_d;
    logic         key_valid_q;
    logic         key_valid_d;

    // Decoded key event for this cycle (at most one per byte)
    logic         do_make;
    logic         do_break;
    logic [8:0]   event_idx;

    logic         timer_load;
    logic         timer_en;
    logic         timer_expired;

    // Any byte that leaves us mid-sequence restarts the silence timer;
    // the timer only runs while a sequence is open and no byte arrives.
    assign timer_load = byte_valid && (state_d != IDLE);
    assign timer_en   = (state_q != IDLE) && !byte_valid;

    ps2_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_seq_timer (
        .fcrystal (fcrystal),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    // Sequence parser: next state and the key event carried by the byte
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        do_make     = 1'b0;
        do_break    = 1'b0;
        event_idx   = 9'h000;

        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_in == PS2_EXT) begin
                        state_d = EXT;
                    end else if (byte_in == PS2_BRK) begin
                        state_d = BRK;
                    end else if (byte_in == PS2_PAUSE) begin
                        state_d     = PAUSE;
                        pause_cnt_d = PS2_PAUSE_SKIP;
                    end else if (!is_ignored(byte_in)) begin
                        do_make   = 1'b1;
                        event_idx = {1'b0, byte_in};
                    end
                end

                EXT: begin
                    if (byte_in == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else if (byte_in == PS2_EXT) begin
                        // Repeated E0: still waiting for the code
                        state_d = EXT;
                    end else if (is_fake_shift(byte_in)) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = IDLE;
                        do_make   = 1'b1;
                        event_idx = {1'b1, byte_in};
                    end
                end

                BRK: begin
                    state_d = IDLE;
                    // A prefix where a code belongs is a protocol error: drop it
                    if ((byte_in != PS2_EXT) && (byte_in != PS2_BRK)) begin
                        do_break  = 1'b1;
                        event_idx = {1'b0, byte_in};
                    end
                end

                EXT_BRK: begin
                    state_d = IDLE;
                    if ((byte_in != PS2_EXT) && (byte_in != PS2_BRK) &&
                        !is_fake_shift(byte_in)) begin
                        do_break  = 1'b1;
                        event_idx = {1'b1, byte_in};
                    end
                end

                PAUSE: begin
                    // Swallow the rest of the pause sequence byte by byte
                    if (pause_cnt_q <= 3'd1) begin
                        pause_cnt_d = 3'd0;
                        state_d     = IDLE;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 3'd1;
                    end
                end

                default: begin
                    state_d     = IDLE;
                    pause_cnt_d = 3'd0;
                end
            endcase
        end else if (timer_expired) begin
            // Keyboard went silent mid-sequence: abandon it
            state_d     = IDLE;
            pause_cnt_d = 3'd0;
        end
    end

    // Bitmap update; only real toggles report a change
    always_comb begin
        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        key_valid_d   = 1'b0;

        if (do_make && !key_down_q[event_idx]) begin
            key_down_d[event_idx] = 1'b1;
            last_change_d         = event_idx;
            key_valid_d           = 1'b1;
        end else if (do_break && key_down_q[event_idx]) begin
            key_down_d[event_idx] = 1'b0;
            last_change_d         = event_idx;
            key_valid_d           = 1'b1;
        end
    end

    // Sequence state registers
    always_ff @(posedge fcrystal or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pause_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
        end
    end

    // Output registers
    always_ff @(posedge fcrystal or posedge rst) begin
        if (rst) begin
            key_down_q    <= '0;
            last_change_q <= 9'h000;
            key_valid_q   <= 1'b0;
        end else begin
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            key_valid_q   <= key_valid_d;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios followed by
// random byte traffic, compared every cycle against a sequence-level model.
module tb_ps2_key_tracker;

    localparam int unsigned TB_T = 20;

    logic         clk;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    ps2_key_tracker #(
        .TIMEOUT_CYCLES(TB_T)
    ) dut (
        .fcrystal    (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending prefix bytes plus the expected outputs
    logic [7:0]   pend[$];
    logic [511:0] model_down;
    logic [8:0]   exp_last;
    logic         exp_valid;
    int           cyc;
    int           last_byte_cyc;

    function automatic logic tb_ignored(input logic [7:0] b);
        return b inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    function automatic logic tb_fake(input logic [7:0] b);
        return b inside {8'h12, 8'h59};
    endfunction

    function automatic void model_key(input logic ext, input logic [7:0] c, input logic make);
        logic [8:0] idx;
        idx = {ext, c};
        if (model_down[idx] != make) begin
            model_down[idx] = make;
            exp_last        = idx;
            exp_valid       = 1'b1;
        end
    endfunction

    // Interpret one received byte against the sequence collected so far
    function automatic void model_byte(input logic [7:0] b);
        logic ext;
        if (pend.size() != 0 && (cyc - last_byte_cyc) > int'(TB_T))
            pend.delete();
        last_byte_cyc = cyc;
        if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
            else if (!tb_ignored(b)) model_key(1'b0, b, 1'b1);
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) pend.delete();
        end else if (pend[pend.size()-1] == 8'hF0) begin
            ext = (pend[0] == 8'hE0);
            pend.delete();
            if (!(b == 8'hE0 || b == 8'hF0) && !(ext && tb_fake(b)))
                model_key(ext, b, 1'b0);
        end else begin
            if (b == 8'hF0) pend.push_back(b);
            else if (b != 8'hE0) begin
                pend.delete();
                if (!tb_fake(b)) model_key(1'b1, b, 1'b1);
            end
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        model_down = '0;
        exp_last   = 9'h000;
        exp_valid  = 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        checks++;
        assert (key_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s key_valid got %0b want %0b", tag, key_valid, exp_valid);
        end
        checks++;
        assert (last_change === exp_last) else begin
            errors++;
            $error("FAIL %s last_change got %03h want %03h", tag, last_change, exp_last);
        end
        checks++;
        assert (key_down === model_down) else begin
            errors++;
            $error("FAIL %s key_down got %0h want %0h", tag, key_down, model_down);
        end
    endtask

    task automatic check_bit(input string tag, input logic [8:0] idx, input logic want);
        checks++;
        assert (key_down[idx] === want) else begin
            errors++;
            $error("FAIL %s key_down[%03h] got %0b want %0b", tag, idx, key_down[idx], want);
        end
    endtask

    // One clock: drive (or not) a byte, advance the model, check outputs
    task automatic tick(input logic v, input logic [7:0] b, input string tag);
        @(negedge clk);
        byte_valid = v;
        byte_in    = v ? b : 8'h00;
        exp_valid  = 1'b0;
        if (v) model_byte(b);
        cyc++;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        tick(1'b1, b, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pulses;

    initial begin
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        cyc        = 0;
        last_byte_cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2, "post_reset");

        // Plain make / break
        send(8'h58, "make_58");
        check_bit("make_58_bit", 9'h058, 1'b1);
        idle(1, "make_58_idle");
        send(8'hF0, "brk_prefix");
        send(8'h58, "brk_58");
        check_bit("brk_58_bit", 9'h058, 1'b0);

        // Extended make / break
        send(8'hE0, "ext_prefix");
        send(8'h75, "ext_make_75");
        check_bit("ext_make_175", 9'h175, 1'b1);
        check_bit("ext_make_075", 9'h075, 1'b0);
        send(8'hE0, "ext_prefix2");
        send(8'hF0, "ext_brk_prefix");
        send(8'h75, "ext_brk_75");
        check_bit("ext_brk_175", 9'h175, 1'b0);
        check_bit("ext_brk_075", 9'h075, 1'b0);

        // Typematic repeat: exactly one pulse
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'h1C, "typematic");
            if (key_valid) pulses++;
        end
        checks++;
        assert (pulses == 1) else begin
            errors++;
            $error("FAIL typematic_pulses got %0d want %0d", pulses, 1);
        end
        send(8'hF0, "typ_brk_prefix");
        send(8'h1C, "typ_brk");

        // Filters
        send(8'hAA, "ignore_aa");
        send(8'hE0, "fake_prefix");
        send(8'h12, "fake_shift");
        send(8'hE1, "pause0");
        send(8'h14, "pause1");
        send(8'h77, "pause2");
        send(8'hE1, "pause3");
        send(8'hF0, "pause4");
        send(8'h14, "pause5");
        send(8'hF0, "pause6");
        send(8'h77, "pause7");
        send(8'h1C, "after_pause");
        check_bit("after_pause_bit", 9'h01C, 1'b1);

        // Timeout: F0 then long silence, 58 is a make
        send(8'hF0, "to_prefix");
        idle(TB_T + 2, "to_idle");
        send(8'h58, "to_make");
        check_bit("to_make_bit", 9'h058, 1'b1);
        // Boundary: byte on the expiring cycle still completes the break
        send(8'hF0, "tob_prefix");
        idle(TB_T - 1, "tob_idle");
        send(8'h58, "tob_break");
        check_bit("tob_break_bit", 9'h058, 1'b0);
        send(8'h58, "tob_remake");
        // One cycle later the break prefix is gone
        send(8'hF0, "toa_prefix");
        idle(TB_T, "toa_idle");
        send(8'h58, "toa_make");
        check_bit("toa_make_bit", 9'h058, 1'b1);

        // Reset mid-sequence, asynchronous clear
        send(8'hE0, "rst_ext_prefix");
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        send(8'h75, "post_rst_75");
        check_bit("post_rst_075", 9'h075, 1'b1);
        check_bit("post_rst_175", 9'h175, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                idle($urandom_range(TB_T - 2, TB_T + 2), "rnd_gap");
            end else if (r < 30) begin
                tick(1'b0, 8'h00, "rnd_idle");
            end else begin
                r = $urandom_range(0, 19);
                case (r)
                    0, 1, 2: b = 8'hE0;
                    3, 4, 5: b = 8'hF0;
                    6:       b = 8'hE1;
                    7:       b = (($urandom_range(0, 1)) != 0) ? 8'h12 : 8'h59;
                    8:       b = 8'hAA;
                    9:       b = 8'(32'hFFFFFFFF * $urandom_range(0, 1));
                    default: b = 8'(8'h10 + $urandom_range(0, 7));
                endcase
                send(b, "rnd_byte");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
